// File: rtl/sprite_tile_renderer.sv
// Sprite tile reader: turns the scan position into tile-relative ROM
// addresses, registers the ROM colour and reports hits per pixel and
// per frame. Position requests are staged and applied at frame start.
//
// Position handshake: a request transfers on a clock edge where
// pos_valid && pos_ready are both high. pos_ready is low while a request
// is held pending, and rises again once frame_start has applied it.
// pos_valid may be held high across cycles; nothing transfers while
// pos_ready is low.
module sprite_tile_renderer #(
  parameter int                           PIXELS_WIDTH     = 80,
  parameter int                           REL_BITS         = 7,
  parameter int                           PIXEL_COLOR_BITS = 8,
  parameter int                           SCAN_BITS        = 10,
  parameter logic [PIXEL_COLOR_BITS-1:0]  TRANSPARENT      = 8'h00,
  parameter logic [PIXEL_COLOR_BITS-1:0]  BG_COLOR         = 8'h00,
  parameter logic [SCAN_BITS-1:0]         RESET_X          = 10'd280,
  parameter logic [SCAN_BITS-1:0]         RESET_Y          = 10'd200
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pix_en,
  input  logic [SCAN_BITS-1:0]        hcount,
  input  logic [SCAN_BITS-1:0]        vcount,
  input  logic                        video_on,
  input  logic                        frame_start,
  input  logic [SCAN_BITS-1:0]        pos_x,
  input  logic [SCAN_BITS-1:0]        pos_y,
  input  logic                        pos_valid,
  output logic                        pos_ready,
  output logic [REL_BITS-1:0]         rel_x,
  output logic [REL_BITS-1:0]         rel_y,
  input  logic [PIXEL_COLOR_BITS-1:0] rom_pixels,
  output logic [PIXEL_COLOR_BITS-1:0] pixel_out,
  output logic                        pixel_hit,
  output logic                        pixel_valid,
  output logic                        frame_drawn
);

  localparam int DW = SCAN_BITS + 1;

  logic [SCAN_BITS-1:0]        r_active_x, r_active_y;
  logic [SCAN_BITS-1:0]        r_pend_x, r_pend_y;
  logic                        r_pend_full;
  logic [REL_BITS-1:0]         r_rel_x, r_rel_y;
  logic                        r_in_box_s1, r_vis_s1;
  logic [PIXEL_COLOR_BITS-1:0] r_pixel_out;
  logic                        r_pixel_hit, r_pixel_valid;
  logic                        r_frame_drawn, r_drawn_acc;

  logic [DW-1:0]               w_dx, w_dy;
  logic                        w_in_box;
  logic                        w_opaque;

  // Relative position with one extra bit so a scan left of / above the
  // sprite shows up as negative instead of wrapping into the tile.
  always_comb begin
    w_dx     = {1'b0, hcount} - {1'b0, r_active_x};
    w_dy     = {1'b0, vcount} - {1'b0, r_active_y};
    w_in_box = !w_dx[DW-1] && (w_dx < DW'(PIXELS_WIDTH)) &&
               !w_dy[DW-1] && (w_dy < DW'(PIXELS_WIDTH));
    w_opaque = r_in_box_s1 && r_vis_s1 && (rom_pixels != TRANSPARENT);
  end

  // Pending/active position registers; active only changes at frame start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active_x  <= RESET_X;
      r_active_y  <= RESET_Y;
      r_pend_x    <= '0;
      r_pend_y    <= '0;
      r_pend_full <= 1'b0;
    end else begin
      if (frame_start && r_pend_full) begin
        r_active_x  <= r_pend_x;
        r_active_y  <= r_pend_y;
        r_pend_full <= 1'b0;
      end
      // Only possible while pending is empty, so it never collides with
      // the apply above; a same-cycle frame_start leaves it for next frame.
      if (pos_valid && !r_pend_full) begin
        r_pend_x    <= pos_x;
        r_pend_y    <= pos_y;
        r_pend_full <= 1'b1;
      end
    end
  end

  // Stage 1: ROM address generation plus in-box and visibility flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rel_x     <= '0;
      r_rel_y     <= '0;
      r_in_box_s1 <= 1'b0;
      r_vis_s1    <= 1'b0;
    end else if (pix_en) begin
      r_rel_x     <= w_in_box ? w_dx[REL_BITS-1:0] : '0;
      r_rel_y     <= w_in_box ? w_dy[REL_BITS-1:0] : '0;
      r_in_box_s1 <= w_in_box;
      r_vis_s1    <= video_on;
    end
  end

  // Stage 2: register ROM colour, substituting background when not opaque.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pixel_out   <= BG_COLOR;
      r_pixel_hit   <= 1'b0;
      r_pixel_valid <= 1'b0;
    end else if (pix_en) begin
      r_pixel_out   <= w_opaque ? rom_pixels : BG_COLOR;
      r_pixel_hit   <= w_opaque;
      r_pixel_valid <= r_vis_s1;
    end
  end

  // Per-frame "sprite drawn" accumulator, published at each frame start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drawn_acc   <= 1'b0;
      r_frame_drawn <= 1'b0;
    end else if (frame_start) begin
      r_frame_drawn <= r_drawn_acc || (pix_en && w_opaque);
      r_drawn_acc   <= 1'b0;
    end else if (pix_en && w_opaque) begin
      r_drawn_acc   <= 1'b1;
    end
  end

  assign pos_ready   = !r_pend_full;
  assign rel_x       = r_rel_x;
  assign rel_y       = r_rel_y;
  assign pixel_out   = r_pixel_out;
  assign pixel_hit   = r_pixel_hit;
  assign pixel_valid = r_pixel_valid;
  assign frame_drawn = r_frame_drawn;

endmodule
